dcache_wb_buffer: RTL and testbench
===================================

Name: dcache_wb_buffer

Overview:
Write-back buffer between the data cache controller (upstream) and Data_Memory (downstream).
- Absorbs dirty-line evictions so the cache's miss refill goes to memory first.
- Drains buffered lines to memory when memory is idle.
- Forwards buffered lines to read requests that hit them.
- Both sides use the existing 256-bit line handshake: enable held until a one-cycle ack.

Parameters:
DEPTH, 2, number of 256-bit line entries (power of two, at least 2).
DATA_W, 256, line width in bits.
ADDR_W, 32, byte address width; the line address is addr[ADDR_W-1:5].

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-low reset.
c_enable_i  in  1  cache request valid, held until c_ack_o.
c_write_i  in  1  1 = eviction write, 0 = line read.
c_addr_i  in  ADDR_W  line-aligned byte address.
c_data_i  in  DATA_W  eviction data.
c_ack_o  out  1  one-cycle completion pulse to cache.
c_data_o  out  DATA_W  read data, valid while c_ack_o=1.
m_enable_o  out  1  memory request, held until m_ack_i.
m_write_o  out  1  memory write select.
m_addr_o  out  ADDR_W  memory address.
m_data_o  out  DATA_W  memory write data.
m_ack_i  in  1  memory completion pulse.
m_data_i  in  DATA_W  memory read data, valid with m_ack_i.
empty_o  out  1  buffer holds no lines and memory side is IDLE.

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0 except empty_o=1; entry count 0; head and tail pointers 0; state IDLE. A memory transaction in flight is abandoned (memory resets with it).
- A request is new only when c_enable_i=1 and c_ack_o=0. The cycle after the ack pulse is never treated as a new request.
- Write accept:
  - New write and count<DEPTH, or a drain completing this cycle: line is stored and c_ack_o=1 on the next cycle (latency 1).
  - Coalesce: if a valid entry has the same line address and is not the head currently being drained, overwrite that entry in place; count is unchanged.
  - Otherwise push at the tail; tail wraps at DEPTH.
  - Full (count=DEPTH, no drain completing): no ack; request stays pending.
- Read forward: new read whose line address matches a valid entry returns that entry's data with c_ack_o=1 next cycle (latency 1); no memory access. If more than one entry matches, the newest wins.
- Read miss: when state is IDLE and count<DEPTH, issue the memory read:
  - m_enable_o=1, m_write_o=0, m_addr_o=c_addr_i; go to RD_MEM.
  - On m_ack_i: c_data_o=m_data_i and c_ack_o=1 in the following cycle; m_enable_o drops the same edge; return to IDLE.
- Ordering: a read miss while count=DEPTH drains first, so the read waits for one drain.
- Drain: state IDLE, count>0, and no read miss eligible this cycle:
  - m_enable_o=1, m_write_o=1, head address/data on m_addr_o/m_data_o; go to WR_MEM.
  - On m_ack_i: pop head (head wraps), count-1, m_enable_o=0, return to IDLE.
  - A started drain always completes; reads arriving meanwhile wait.
- States: IDLE, RD_MEM, WR_MEM.
  - IDLE -> RD_MEM on eligible read miss (priority).
  - IDLE -> WR_MEM on drain.
  - RD_MEM/WR_MEM -> IDLE on m_ack_i.
  - Memory outputs are registered and stable throughout a transaction.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- empty_o is combinational: (count==0 && state==IDLE). Benches wait on it before flushing.
- count width is clog2(DEPTH)+1. count never exceeds DEPTH and never goes below 0; assertions check both.

Test Plan:
1. Eviction write, idle memory: write 0x0400, data A -> c_ack_o at cycle+1. Buffer then issues m_write of 0x0400/A; after m_ack_i, empty_o=1 and Data_Memory line 32 = A.
2. Read forwarding: evict 0x0040 (data B), then read 0x0040 before the drain completes -> c_ack_o at cycle+1 with c_data_o=B, and no m_write_o=0 request appears on the memory side.
3. Read priority: evict 0x0080 then read miss 0x00C0 -> memory sees read 0x00C0 first (after any drain already started), then write 0x0080. The cache gets memory line 6 data.
4. Full buffer, DEPTH=2: evict 0x0000, 0x0020, then 0x0060 -> third write has no ack until the first drain's m_ack_i. Its ack then arrives next cycle and count stays 2.
5. Coalesce: evict 0x00A0 data C, then 0x00A0 data D while not being drained -> count=1. The single memory write carries D.
6. Reset mid-transaction: assert rst_i=0 during WR_MEM -> m_enable_o=0 and c_ack_o=0 immediately, empty_o=1. After release, no stale write is issued.

Source files
------------

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the D-cache controller and Data_Memory: absorbs evictions, forwards hits, drains when memory is idle.
// Latency: write accept / read forward ack 1 cycle after a new request; read miss acks 1 cycle after m_ack_i.
// Backpressure: a write to a full buffer stays pending (no ack) until a drain completes; read misses wait for IDLE and a free slot.
module dcache_wb_buffer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_enable_i,
    input  logic              c_write_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_data_i,
    output logic              c_ack_o,
    output logic [DATA_W-1:0] c_data_o,
    output logic              m_enable_o,
    output logic              m_write_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ack_i,
    input  logic [DATA_W-1:0] m_data_i,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_W - 5;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] WR_MEM = 2'd2;

    logic [1:0]        state;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [LW-1:0]     ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [LW-1:0] req_line;
    logic          req_new, wr_new, rd_new;
    logic          full, drain_done;
    logic          fwd_hit, coal_hit;
    logic [PW-1:0] fwd_idx, coal_idx;
    logic          wr_acc, rd_fwd, rd_miss_go, drain_go;
    logic          push, pop, coal_head;

    assign req_line   = c_addr_i[ADDR_W-1:5];
    // The ack cycle itself never counts as a fresh request; the pending read owns the port while in RD_MEM.
    assign req_new    = c_enable_i & ~c_ack_o;
    assign wr_new     = req_new & c_write_i;
    assign rd_new     = req_new & ~c_write_i & (state != RD_MEM);
    assign full       = (count == CW'(DEPTH));
    assign drain_done = (state == WR_MEM) & m_ack_i;

    // Search valid entries oldest to newest: last match is the newest (forward); the head under drain is excluded from coalescing.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_idx  = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (ent_addr[idx] == req_line)) begin
                fwd_hit = 1'b1;
                fwd_idx = idx;
                if (!((k == 0) && (state == WR_MEM))) begin
                    coal_hit = 1'b1;
                    coal_idx = idx;
                end
            end
        end
    end

    assign wr_acc     = wr_new & (~full | drain_done);
    assign rd_fwd     = rd_new & fwd_hit;
    assign rd_miss_go = rd_new & ~fwd_hit & (state == IDLE) & ~full;
    assign drain_go   = (state == IDLE) & (count != '0) & ~rd_miss_go;
    assign push       = wr_acc & ~coal_hit;
    assign pop        = drain_done;
    // A coalescing write into the head in the same cycle a drain launches must reach memory, not the stale copy.
    assign coal_head  = wr_acc & coal_hit & (coal_idx == head);

    assign empty_o = (count == '0) && (state == IDLE);

    // Line storage: validity is tracked by head/count, so the array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            if (coal_hit) begin
                ent_data[coal_idx] <= c_data_i;
            end else begin
                ent_addr[tail] <= req_line;
                ent_data[tail] <= c_data_i;
            end
        end
    end

    // Control: pointers, occupancy, cache-side ack/data and the memory-side transaction FSM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            c_ack_o    <= 1'b0;
            c_data_o   <= '0;
            m_enable_o <= 1'b0;
            m_write_o  <= 1'b0;
            m_addr_o   <= '0;
            m_data_o   <= '0;
        end else begin
            c_ack_o <= wr_acc | rd_fwd;
            if (rd_fwd) begin
                c_data_o <= ent_data[fwd_idx];
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    if (rd_miss_go) begin
                        m_enable_o <= 1'b1;
                        m_write_o  <= 1'b0;
                        m_addr_o   <= c_addr_i;
                        state      <= RD_MEM;
                    end else if (drain_go) begin
                        m_enable_o <= 1'b1;
                        m_write_o  <= 1'b1;
                        m_addr_o   <= {ent_addr[head], 5'b0};
                        m_data_o   <= coal_head ? c_data_i : ent_data[head];
                        state      <= WR_MEM;
                    end
                end
                RD_MEM: begin
                    if (m_ack_i) begin
                        c_data_o   <= m_data_i;
                        c_ack_o    <= 1'b1;
                        m_enable_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WR_MEM: begin
                    if (m_ack_i) begin
                        head       <= head + 1'b1;
                        m_enable_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    m_enable_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Occupancy stays within 0..DEPTH.
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_i) count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i) pop |-> (count != '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i) (push && !pop) |-> !full);

endmodule

// File: tb/tb_dcache_wb_buffer.sv
`timescale 1ns/1ps
// Bench for dcache_wb_buffer: directed scenarios plus randomized traffic against a transparent-memory model.
// The buffer must be invisible to the cache: every read returns the latest data written to that line.
// Memory side is a latency-configurable responder that logs completed transactions.
module tb_dcache_wb_buffer;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              c_enable_i = 1'b0;
    logic              c_write_i = 1'b0;
    logic [ADDR_W-1:0] c_addr_i = '0;
    logic [DATA_W-1:0] c_data_i = '0;
    logic              c_ack_o;
    logic [DATA_W-1:0] c_data_o;
    logic              m_enable_o;
    logic              m_write_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ack_i = 1'b0;
    logic [DATA_W-1:0] m_data_i = '0;
    logic              empty_o;

    dcache_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_enable_i(c_enable_i), .c_write_i(c_write_i), .c_addr_i(c_addr_i), .c_data_i(c_data_i),
        .c_ack_o(c_ack_o), .c_data_o(c_data_o),
        .m_enable_o(m_enable_o), .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
        .m_ack_i(m_ack_i), .m_data_i(m_data_i), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic wr; logic [DATA_W-1:0] d; } exp_t;
    typedef struct packed { logic wr; logic [ADDR_W-1:0] a; } mlog_t;

    exp_t              exp_q[$];
    mlog_t             mlog[$];
    int                wack_cyc[$];
    logic [DATA_W-1:0] mem    [int];
    logic [DATA_W-1:0] shadow [int];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mem_lat = 2;
    bit rand_lat = 1'b0;
    bit en_seen = 1'b0;
    int wcnt = 0;
    int mline;
    int last_ack_cyc = 0;

    function automatic logic [DATA_W-1:0] init_val(int line);
        logic [31:0] w;
        w = (32'(line) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        return {8{w}};
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(int line);
        return mem.exists(line) ? mem[line] : init_val(line);
    endfunction

    function automatic logic [DATA_W-1:0] shadow_rd(int line);
        return shadow.exists(line) ? shadow[line] : mem_rd(line);
    endfunction

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory responder: acks after mem_lat cycles of a held request, logs each completed transaction.
    always @(negedge clk_i) begin
        m_ack_i = 1'b0;
        if (m_enable_o && rst_i) begin
            en_seen = 1'b1;
            wcnt++;
            if (wcnt >= mem_lat) begin
                wcnt  = 0;
                mline = int'(m_addr_o[ADDR_W-1:5]);
                if (m_write_o) begin
                    mem[mline] = m_data_o;
                    wack_cyc.push_back(cyc);
                end else begin
                    m_data_i = mem_rd(mline);
                end
                mlog.push_back({m_write_o, m_addr_o});
                m_ack_i = 1'b1;
                if (rand_lat) mem_lat = $urandom_range(1, 4);
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: every cache ack consumes one expectation; reads are data-checked.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i && c_ack_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_ack: got ack with data %h, required no ack", c_data_o);
            end else begin
                e = exp_q.pop_front();
                if (!e.wr) check("rd_data", c_data_o, e.d);
            end
        end
    end

    task automatic cache_op(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d, output int lat);
        int line;
        line = int'(addr[ADDR_W-1:5]);
        if (wr) begin
            shadow[line] = d;
            exp_q.push_back({1'b1, {DATA_W{1'b0}}});
        end else begin
            exp_q.push_back({1'b0, shadow_rd(line)});
        end
        c_enable_i = 1'b1;
        c_write_i  = wr;
        c_addr_i   = addr;
        c_data_i   = d;
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
        end while (!c_ack_o && lat < 300);
        if (!c_ack_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, required ack (addr %h)", lat, addr);
        end
        last_ack_cyc = cyc;
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!empty_o && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_int(name, int'(empty_o), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nrd;
        logic [DATA_W-1:0] da, db, dc, dd, de;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_c_ack", DATA_W'(c_ack_o), '0);
        check("rst_c_data", c_data_o, '0);
        check("rst_m_enable", DATA_W'(m_enable_o), '0);
        check("rst_m_write", DATA_W'(m_write_o), '0);
        check("rst_m_addr", DATA_W'(m_addr_o), '0);
        check("rst_m_data", m_data_o, '0);
        check("rst_empty", DATA_W'(empty_o), DATA_W'(1));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: eviction into idle buffer, then drain to memory
        mem_lat = 3;
        mlog.delete();
        da = rand_line();
        cache_op(1'b1, 32'h0400, da, lat);
        check_int("t1_wr_latency", lat, 1);
        wait_empty("t1_empty");
        check("t1_mem_line32", mem_rd(32), da);
        check_int("t1_mem_ops", mlog.size(), 1);
        if (mlog.size() > 0) check("t1_mem_op0", DATA_W'(mlog[0]), DATA_W'({1'b1, 32'h0400}));

        // 2: read forwarded from the buffer while its drain is in progress
        mem_lat = 10;
        mlog.delete();
        db = rand_line();
        cache_op(1'b1, 32'h0040, db, lat);
        cache_op(1'b0, 32'h0040, '0, lat);
        check_int("t2_fwd_latency", lat, 1);
        wait_empty("t2_empty");
        nrd = 0;
        foreach (mlog[i]) if (!mlog[i].wr) nrd++;
        check_int("t2_mem_reads", nrd, 0);

        // 3: read miss takes priority over a queued (not yet started) drain
        mem_lat = 6;
        mlog.delete();
        cache_op(1'b1, 32'h0080, rand_line(), lat);
        cache_op(1'b1, 32'h0100, rand_line(), lat);
        cache_op(1'b0, 32'h00C0, '0, lat);
        wait_empty("t3_empty");
        check_int("t3_mem_ops", mlog.size(), 3);
        if (mlog.size() == 3) begin
            check("t3_op0", DATA_W'(mlog[0]), DATA_W'({1'b1, 32'h0080}));
            check("t3_op1", DATA_W'(mlog[1]), DATA_W'({1'b0, 32'h00C0}));
            check("t3_op2", DATA_W'(mlog[2]), DATA_W'({1'b1, 32'h0100}));
        end

        // 4: full buffer holds off the third eviction until the first drain acks
        mem_lat = 6;
        mlog.delete();
        wack_cyc.delete();
        cache_op(1'b1, 32'h0000, rand_line(), lat);
        cache_op(1'b1, 32'h0020, rand_line(), lat);
        cache_op(1'b1, 32'h0060, rand_line(), lat);
        if (wack_cyc.size() > 0) check_int("t4_full_ack_cycle", last_ack_cyc, wack_cyc[0] + 1);
        else check_int("t4_first_drain_seen", 0, 1);
        wait_empty("t4_empty");
        check_int("t4_mem_ops", mlog.size(), 3);
        if (mlog.size() == 3) begin
            check("t4_op0", DATA_W'(mlog[0]), DATA_W'({1'b1, 32'h0000}));
            check("t4_op1", DATA_W'(mlog[1]), DATA_W'({1'b1, 32'h0020}));
            check("t4_op2", DATA_W'(mlog[2]), DATA_W'({1'b1, 32'h0060}));
        end

        // 5: second eviction of a queued line coalesces into it
        mem_lat = 8;
        mlog.delete();
        dc = rand_line();
        dd = rand_line();
        cache_op(1'b1, 32'h0100, rand_line(), lat);
        cache_op(1'b1, 32'h00A0, dc, lat);
        cache_op(1'b1, 32'h00A0, dd, lat);
        wait_empty("t5_empty");
        check_int("t5_mem_ops", mlog.size(), 2);
        if (mlog.size() == 2) check("t5_op1", DATA_W'(mlog[1]), DATA_W'({1'b1, 32'h00A0}));
        check("t5_mem_line5", mem_rd(5), dd);
        cache_op(1'b0, 32'h00A0, '0, lat);

        // 6: reset during a drain abandons it
        mem_lat = 20;
        de = rand_line();
        cache_op(1'b1, 32'h0200, de, lat);
        lat = 0;
        while (!(m_enable_o && m_write_o) && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check_int("t6_in_wr_mem", int'(m_enable_o && m_write_o), 1);
        #1;
        rst_i = 1'b0;
        #1;
        check_int("t6_rst_m_enable", int'(m_enable_o), 0);
        check_int("t6_rst_c_ack", int'(c_ack_o), 0);
        check_int("t6_rst_empty", int'(empty_o), 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        en_seen = 1'b0;
        mlog.delete();
        repeat (30) @(posedge clk_i);
        #1;
        check_int("t6_no_stale_req", int'(en_seen), 0);
        check_int("t6_empty_after", int'(empty_o), 1);
        shadow.delete();

        // Randomized traffic over a small set of lines
        rand_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 7)) << 5;
            cache_op(1'($urandom_range(0, 1)), a, rand_line(), lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk_i);
            #1;
        end
        wait_empty("rand_empty");
        for (int l = 0; l < 8; l++) check("rand_mem_final", mem_rd(l), shadow_rd(l));
        repeat (3) @(posedge clk_i);
        #1;
        check_int("exp_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
